conv_layer_scheduler: RTL and testbench

Sequences one convolution pass of an image through the shared conv kernel array and input interface. Iterates over every kernel (feature map) and every output row. For each step it issues commands to the input interface, counts the KERNEL_SIZE² multiply-accumulate taps, and presents a valid result window with downstream back-pressure. It sits between the layer-level start/finish handshake and the input interface/kernel array pair, replacing free-running sequencing with an explicit per-row state machine.

---
 rtl/conv_layer_scheduler.sv | 130 +++++++++++++
 tb/tb_conv_layer_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_scheduler.sv
// Per-row sequencer for one convolution pass: loads weights per kernel, loads each
// row window, issues KERNEL_SIZE^2 SHIFT taps, then holds the result until accepted.
module conv_layer_scheduler #(
    parameter int KERNEL_SIZE  = 3,
    parameter int IMAGE_SIZE   = 8,
    parameter int ARRAY_SIZE   = 6,
    parameter int ARRAY_WIDTH  = 3,
    parameter int TOTAL_WEIGHT = 4,
    parameter int WEIGHT_WIDTH = 2,
    parameter int TAP_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [1:0]              input_interface_ack,
    input  logic                    out_ready,
    output logic [1:0]              input_interface_cmd,
    output logic [TAP_WIDTH-1:0]    kernel_tap,
    output logic                    valid,
    output logic [WEIGHT_WIDTH-1:0] feature_idx,
    output logic [ARRAY_WIDTH-1:0]  feature_row,
    output logic                    image_calc_fin,
    output logic                    busy,
    output logic [2:0]              fsm_state
);

    // Never schedule more rows than the image actually yields as windows.
    localparam int ROWS = (ARRAY_SIZE < IMAGE_SIZE - KERNEL_SIZE + 1) ?
                          ARRAY_SIZE : IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam logic [TAP_WIDTH-1:0]    TAP_LAST = TAP_WIDTH'(KERNEL_SIZE * KERNEL_SIZE - 1);
    localparam logic [ARRAY_WIDTH-1:0]  ROW_LAST = ARRAY_WIDTH'(ROWS - 1);
    localparam logic [WEIGHT_WIDTH-1:0] IDX_LAST = WEIGHT_WIDTH'(TOTAL_WEIGHT - 1);

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_LOAD_R = 2'b01;
    localparam logic [1:0] CMD_SHIFT  = 2'b10;
    localparam logic [1:0] CMD_LOAD_W = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_W   = 3'd1,
        S_LOAD_ROW = 3'd2,
        S_CALC     = 3'd3,
        S_OUT      = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    state_t                  state, state_next;
    logic [TAP_WIDTH-1:0]    tap, tap_next;
    logic [WEIGHT_WIDTH-1:0] idx, idx_next;
    logic [ARRAY_WIDTH-1:0]  row, row_next;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S_IDLE;
            tap   <= '0;
            idx   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            tap   <= tap_next;
            idx   <= idx_next;
            row   <= row_next;
        end
    end

    // Handshake: a load state advances on the edge its ack bit is sampled high;
    // OUT advances on the edge out_ready is sampled high while valid is asserted.
    always_comb begin
        state_next = state;
        tap_next   = '0;
        idx_next   = idx;
        row_next   = row;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_next = S_LOAD_W;
                    idx_next   = '0;
                    row_next   = '0;
                end
            end
            S_LOAD_W: begin
                if (input_interface_ack[1]) state_next = S_LOAD_ROW;
            end
            S_LOAD_ROW: begin
                if (input_interface_ack[0]) state_next = S_CALC;
            end
            S_CALC: begin
                if (tap == TAP_LAST) state_next = S_OUT;
                else                 tap_next   = tap + 1'b1;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (row != ROW_LAST) begin
                        row_next   = row + 1'b1;
                        state_next = S_LOAD_ROW;
                    end else if (idx != IDX_LAST) begin
                        row_next   = '0;
                        idx_next   = idx + 1'b1;
                        state_next = S_LOAD_W;
                    end else begin
                        state_next = S_FIN;
                    end
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        input_interface_cmd = CMD_NOP;
        case (state)
            S_LOAD_W:   input_interface_cmd = CMD_LOAD_W;
            S_LOAD_ROW: input_interface_cmd = CMD_LOAD_R;
            S_CALC:     input_interface_cmd = CMD_SHIFT;
            default:    input_interface_cmd = CMD_NOP;
        endcase
    end

    // tap is forced to zero outside CALC, so it can drive kernel_tap directly.
    assign kernel_tap     = tap;
    assign valid          = (state == S_OUT);
    assign image_calc_fin = (state == S_FIN);
    assign busy           = (state != S_IDLE);
    assign feature_idx    = idx;
    assign feature_row    = row;
    assign fsm_state      = state;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: cycle k is the k-th cycle after the edge
// that samples enable in IDLE (LOAD_W is visible in cycle 1).
module tb_conv_layer_scheduler;

    localparam int M_FULL   = 0;
    localparam int M_DELAY  = 1;
    localparam int M_STALL  = 2;
    localparam int M_SPUR   = 3;
    localparam int M_B2B    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] ack;
    logic       out_ready;
    logic [1:0] cmd;
    logic [3:0] kernel_tap;
    logic       valid;
    logic [1:0] feature_idx;
    logic [2:0] feature_row;
    logic       image_calc_fin;
    logic       busy;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] exp_q[$];
    int         fin_q[$];
    int         cnt_a;
    int         cnt_b;

    // clock / reset
    always #5 clk = ~clk;

    conv_layer_scheduler dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .input_interface_ack (ack),
        .out_ready           (out_ready),
        .input_interface_cmd (cmd),
        .kernel_tap          (kernel_tap),
        .valid               (valid),
        .feature_idx         (feature_idx),
        .feature_row         (feature_row),
        .image_calc_fin      (image_calc_fin),
        .busy                (busy),
        .fsm_state           (fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b1;
        enable    = 1'b0;
        ack       = 2'b00;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd"},   32'(cmd), 0);
        chk({tag, "_tap"},   32'(kernel_tap), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_idx"},   32'(feature_idx), 0);
        chk({tag, "_row"},   32'(feature_row), 0);
        chk({tag, "_fin"},   32'(image_calc_fin), 0);
        chk({tag, "_busy"},  32'(busy), 0);
    endtask

    // driver + monitor for one pass; starts with the DUT idle and enable sampled at edge 0
    task automatic run_pass(input int mode, input int n_cyc);
        int tap_seen;
        enable    = 1'b1;
        ack       = 2'b11;
        out_ready = 1'b1;
        fin_q.delete();
        cnt_a    = 0;
        cnt_b    = 0;
        tap_seen = 0;
        for (int c = 1; c <= n_cyc; c++) begin
            tick();
            enable    = (mode == M_B2B);
            ack       = 2'b11;
            out_ready = 1'b1;
            case (mode)
                M_DELAY: if (c >= 24 && c <= 27) ack = 2'b10;
                M_STALL: if (c >= 134 && c <= 136) out_ready = 1'b0;
                M_SPUR: begin
                    if (c == 2 || c == 3) ack = 2'b10;
                    if (c == 7 || c == 271) enable = 1'b1;
                end
                default: ;
            endcase

            if (image_calc_fin) fin_q.push_back(c);

            if (mode == M_FULL) begin
                if (c == 1)  chk("full_c1_cmd", 32'(cmd), 3);
                if (c == 2)  chk("full_c2_cmd", 32'(cmd), 1);
                if (c == 3)  chk("full_c3_tap", 32'({cmd, kernel_tap}), 32'({2'b10, 4'd0}));
                if (c == 11) chk("full_c11_tap", 32'({cmd, kernel_tap}), 32'({2'b10, 4'd8}));
                if (c == 12) chk("full_c12_out", 32'({valid, cmd}), 32'({1'b1, 2'b00}));
                if (c == 270) chk("full_busy_270", 32'(busy), 0);
                if (valid) begin
                    cnt_a++;
                    if (exp_q.size() == 0) chk("full_extra_valid", 1, 0);
                    else chk("full_idx_row", 32'({feature_idx, feature_row}), 32'(exp_q.pop_front()));
                end
            end

            if (mode == M_DELAY && feature_idx == 2'd0 && feature_row == 3'd2) begin
                if (cmd == 2'b01) cnt_a++;
                if (cmd == 2'b10) begin
                    chk("delay_tap_seq", 32'(kernel_tap), 32'(tap_seen));
                    tap_seen++;
                    cnt_b++;
                end
                if (c == 38) chk("delay_c38_valid", 32'(valid), 1);
            end

            if (mode == M_STALL) begin
                if (valid && feature_idx == 2'd1 && feature_row == 3'd5) cnt_a++;
                if (c == 136) chk("stall_frozen", 32'({valid, feature_idx, feature_row}),
                                  32'({1'b1, 2'd1, 3'd5}));
                if (c == 138) chk("stall_next", 32'({cmd, feature_idx, feature_row}),
                                  32'({2'b11, 2'd2, 3'd0}));
            end

            if (mode == M_SPUR) begin
                if (c == 3 || c == 4) chk("spur_hold_loadrow", 32'(cmd), 1);
                if (c == 5) chk("spur_calc_start", 32'({cmd, kernel_tap}), 32'({2'b10, 4'd0}));
                if (c == 8) chk("spur_calc_tap", 32'({cmd, kernel_tap}), 32'({2'b10, 4'd3}));
                if (c == 272 || c == 273) chk("spur_idle_after_fin", 32'(busy), 0);
            end
        end
        enable    = 1'b0;
        ack       = 2'b00;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b1;
        enable    = 1'b0;
        ack       = 2'b00;
        out_ready = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b0;

        // all handshakes high: 24 windows in (idx,row) order, fin in cycle 269 only
        for (int i = 0; i < 4; i++)
            for (int r = 0; r < 6; r++)
                exp_q.push_back({2'(i), 3'(r)});
        run_pass(M_FULL, 272);
        chk("full_valid_count", 32'(cnt_a), 24);
        chk("full_queue_empty", 32'(exp_q.size()), 0);
        chk("full_fin_count", 32'(fin_q.size()), 1);
        if (fin_q.size() > 0) chk("full_fin_cycle", 32'(fin_q[0]), 269);
        do_reset();

        // kernel 2 row 3 LOAD_ROW is cycle 2+134+33=169, so tap 5 is cycle 175
        enable    = 1'b1;
        tick();
        enable    = 1'b0;
        ack       = 2'b11;
        out_ready = 1'b1;
        repeat (174) tick();
        chk("midcalc_pos", 32'({cmd, feature_idx, feature_row, kernel_tap}),
            32'({2'b10, 2'd2, 3'd3, 4'd5}));
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("midcalc_rst");
        rst_n = 1'b0;
        ack   = 2'b00;
        tick();
        chk("midcalc_idle", 32'(busy), 0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("restart_state", 32'({busy, cmd, feature_idx, feature_row}),
            32'({1'b1, 2'b11, 2'd0, 3'd0}));
        do_reset();

        // ack[0] withheld in cycles 24..27 on row 2: LOAD_ROW 24..28, CALC 29..37
        run_pass(M_DELAY, 275);
        chk("delay_loadrow_len", 32'(cnt_a), 5);
        chk("delay_shift_len", 32'(cnt_b), 9);
        chk("delay_fin_count", 32'(fin_q.size()), 1);
        if (fin_q.size() > 0) chk("delay_fin_cycle", 32'(fin_q[0]), 273);
        do_reset();

        // out_ready low in cycles 134..136 at (1,5): valid for 4 cycles, fin moves by 3
        run_pass(M_STALL, 274);
        chk("stall_valid_len", 32'(cnt_a), 4);
        chk("stall_fin_count", 32'(fin_q.size()), 1);
        if (fin_q.size() > 0) chk("stall_fin_cycle", 32'(fin_q[0]), 272);
        do_reset();

        // ack[1]-only during LOAD_ROW costs 2 cycles; enable in CALC and FIN is ignored
        run_pass(M_SPUR, 273);
        chk("spur_fin_count", 32'(fin_q.size()), 1);
        if (fin_q.size() > 0) chk("spur_fin_cycle", 32'(fin_q[0]), 271);
        do_reset();

        // enable held high: second pass restarts from IDLE in cycle 270
        run_pass(M_B2B, 541);
        chk("b2b_fin_count", 32'(fin_q.size()), 2);
        if (fin_q.size() > 0) chk("b2b_fin1_cycle", 32'(fin_q[0]), 269);
        if (fin_q.size() > 1) chk("b2b_fin_gap", 32'(fin_q[1] - fin_q[0]), 270);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
